// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO pointer/flag controller: pointer width
// derivation and status-flag bit indices.
package fifo_pkg;

  typedef enum logic [1:0] {
    ST_FULL  = 2'd0,
    ST_EMPTY = 2'd1,
    ST_OVF   = 2'd2,
    ST_UDF   = 2'd3
  } status_bit_e;

  localparam int unsigned STATUS_W = 4;

  // One extra MSB distinguishes full from empty when the LSBs match.
  function automatic int unsigned ptr_width(input int unsigned aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer register: advances by one when inc is high; ptr_next is the
// value the register takes on the coming edge.
module fifo_ptr #(
  parameter int unsigned PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] ptr_next
);

  logic [PTR_W-1:0] ptr_q;

  assign ptr_next = inc ? ptr_q + PTR_W'(1) : ptr_q;
  assign ptr      = ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_next;
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller for a synchronous FIFO in front of a dual-port
// RAM. Optional almost_full/almost_empty flags are enabled by FIFO_CTRL_THRESH_EN.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned DATA_WIDTH    = 8
`ifdef FIFO_CTRL_THRESH_EN
  ,
  parameter int unsigned AFULL_THRESH  = (1 << ADDRESS_WIDTH) - 1,
  parameter int unsigned AEMPTY_THRESH = 1
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [ADDRESS_WIDTH:0]   count,
  output logic                     overflow,
  output logic                     underflow,
`ifdef FIFO_CTRL_THRESH_EN
  output logic                     almost_full,
  output logic                     almost_empty,
`endif
  output logic                     ram_write_en,
  output logic [ADDRESS_WIDTH-1:0] ram_write_address,
  output logic [ADDRESS_WIDTH-1:0] ram_read_address,
  output logic [DATA_WIDTH-1:0]    ram_write_data,
  input  logic [DATA_WIDTH-1:0]    ram_read_data
);

  localparam int unsigned PW = ptr_width(ADDRESS_WIDTH);

  logic [PW-1:0]       wptr, wptr_next, rptr, rptr_next;
  logic [STATUS_W-1:0] status;
  logic                push_acc, pop_acc;
  logic                ovf_q, ovf_d, udf_q, udf_d;

  fifo_ptr #(.PTR_W(PW)) u_wptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (push_acc),
    .ptr      (wptr),
    .ptr_next (wptr_next)
  );

  fifo_ptr #(.PTR_W(PW)) u_rptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (pop_acc),
    .ptr      (rptr),
    .ptr_next (rptr_next)
  );

  always_comb begin
    status           = '0;
    status[ST_EMPTY] = (wptr == rptr);
    status[ST_FULL]  = (wptr[ADDRESS_WIDTH-1:0] == rptr[ADDRESS_WIDTH-1:0]) &&
                       (wptr[ADDRESS_WIDTH] != rptr[ADDRESS_WIDTH]);
    status[ST_OVF]   = ovf_q;
    status[ST_UDF]   = udf_q;
  end

  assign push_acc = wr && !status[ST_FULL];
  assign pop_acc  = rd && !status[ST_EMPTY];
  assign ovf_d    = ovf_q || (wr && status[ST_FULL]);
  assign udf_d    = udf_q || (rd && status[ST_EMPTY]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign full      = status[ST_FULL];
  assign empty     = status[ST_EMPTY];
  assign overflow  = status[ST_OVF];
  assign underflow = status[ST_UDF];
  assign count     = wptr - rptr;

  // Read address leads rptr by the pending pop so the RAM's registered read
  // address always lands on the head word.
  assign ram_write_en      = push_acc && rst_n;
  assign ram_write_address = wptr[ADDRESS_WIDTH-1:0];
  assign ram_read_address  = rptr_next[ADDRESS_WIDTH-1:0];
  assign ram_write_data    = wr_data;
  assign rd_data           = ram_read_data;

`ifdef FIFO_CTRL_THRESH_EN
  logic [PW-1:0] count_next;
  logic          afull_q, afull_d, aempty_q, aempty_d;

  assign count_next = wptr_next - rptr_next;
  assign afull_d    = (count_next >= PW'(AFULL_THRESH));
  assign aempty_d   = (count_next <= PW'(AEMPTY_THRESH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl (depth 4) with a RAM model and a
// queue-based reference; FIFO_CTRL_THRESH_EN enables threshold checks.
module tb_fifo_ctrl;

  localparam int AW    = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr = 1'b0, rd = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rd_data, ram_write_data, ram_read_data;
  logic          full, empty, overflow, underflow, ram_write_en;
  logic [AW:0]   count;
  logic [AW-1:0] ram_write_address, ram_read_address;
`ifdef FIFO_CTRL_THRESH_EN
  logic          almost_full, almost_empty;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  fifo_ctrl #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW)
`ifdef FIFO_CTRL_THRESH_EN
    ,
    .AFULL_THRESH  (3),
    .AEMPTY_THRESH (1)
`endif
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .wr                (wr),
    .wr_data           (wr_data),
    .rd                (rd),
    .rd_data           (rd_data),
    .full              (full),
    .empty             (empty),
    .count             (count),
    .overflow          (overflow),
    .underflow         (underflow),
`ifdef FIFO_CTRL_THRESH_EN
    .almost_full       (almost_full),
    .almost_empty      (almost_empty),
`endif
    .ram_write_en      (ram_write_en),
    .ram_write_address (ram_write_address),
    .ram_read_address  (ram_read_address),
    .ram_write_data    (ram_write_data),
    .ram_read_data     (ram_read_data)
  );

  // Dual-port RAM: registered write and read address, asynchronous read.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] raddr_q;
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_write_address] <= ram_write_data;
    raddr_q <= ram_read_address;
  end
  assign ram_read_data = mem[raddr_q];

  // Reference: queue of stored words plus push/pop tallies for addressing.
  int          q[$];
  bit          m_ovf, m_udf;
  int unsigned m_wcnt, m_rcnt;
  bit          m_pa, m_pp, m_f, m_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_wcnt = 0; m_rcnt = 0;
    end else begin
      m_f  = (q.size() == DEPTH);
      m_e  = (q.size() == 0);
      m_pa = wr && !m_f;
      m_pp = rd && !m_e;
      if (wr && m_f) m_ovf = 1;
      if (rd && m_e) m_udf = 1;
      if (m_pp) begin void'(q.pop_front()); m_rcnt++; end
      if (m_pa) begin q.push_back(int'(wr_data)); m_wcnt++; end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    automatic bit pa = wr && (q.size() < DEPTH);
    automatic bit pp = rd && (q.size() > 0);
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("count", 32'(count), 32'(q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
    chk("ram_write_en", 32'(ram_write_en), 32'(pa && rst_n));
    chk("ram_write_address", 32'(ram_write_address), (m_wcnt % DEPTH));
    chk("ram_read_address", 32'(ram_read_address), ((m_rcnt + 32'(pp)) % DEPTH));
    chk("ram_write_data", 32'(ram_write_data), 32'(wr_data));
    if (q.size() > 0) chk("rd_data", 32'(rd_data), 32'(q[0]));
`ifdef FIFO_CTRL_THRESH_EN
    chk("almost_full", 32'(almost_full), 32'(q.size() >= 3));
    chk("almost_empty", 32'(almost_empty), 32'(q.size() <= 1));
`endif
  end

  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
    wr = w; wr_data = d; rd = r;
    @(posedge clk); #1;
    wr = 0; rd = 0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    chk("rst_ram_write_en", 32'(ram_write_en), 32'd0);
    chk("rst_ram_read_address", 32'(ram_read_address), 32'd0);
`ifdef FIFO_CTRL_THRESH_EN
    chk("rst_almost_full", 32'(almost_full), 32'd0);
    chk("rst_almost_empty", 32'(almost_empty), 32'd1);
`endif
  endtask

  logic [DW-1:0] pat [4];
  logic [DW-1:0] last;

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_reset_vals();
    rst_n = 1'b1;
    cyc(0, 8'h00, 0);
    chk_reset_vals();

`ifdef FIFO_CTRL_THRESH_EN
    cyc(1, 8'h01, 0);
    chk("af_1", 32'(almost_full), 32'd0); chk("ae_1", 32'(almost_empty), 32'd1);
    cyc(1, 8'h02, 0);
    chk("ae_2", 32'(almost_empty), 32'd0);
    cyc(1, 8'h03, 0);
    chk("af_3", 32'(almost_full), 32'd1);
    repeat (3) cyc(0, 8'h00, 1);
`endif

    pat[0] = 8'hA1; pat[1] = 8'hB2; pat[2] = 8'hC3; pat[3] = 8'hD4;
    for (int i = 0; i < 4; i++) cyc(1, pat[i], 0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", 32'(rd_data), 32'(pat[i]));
      cyc(0, 8'h00, 1);
    end
    chk("drain_empty", 32'(empty), 32'd1);

    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
    for (int i = 0; i < 4; i++) cyc(1, pat[i], 0);
    cyc(1, 8'hEE, 0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd4);
    cyc(1, 8'hEE, 1);
    chk("pp_full_count", 32'(count), 32'd3);
    chk("pp_full_head", 32'(rd_data), 32'h22);
    for (int i = 1; i < 4; i++) begin
      chk("no_ee", 32'(rd_data), 32'(pat[i]));
      cyc(0, 8'h00, 1);
    end

    cyc(0, 8'h00, 1);
    chk("udf_set", 32'(underflow), 32'd1);
    cyc(1, 8'h55, 1);
    chk("pp_empty_count", 32'(count), 32'd1);
    chk("pp_empty_data", 32'(rd_data), 32'h55);

    last = 8'h55;
    for (int i = 0; i < 10; i++) begin
      chk("wrap_head", 32'(rd_data), 32'(last));
      last = 8'(8'h60 + i);
      cyc(1, last, 1);
      chk("wrap_count", 32'(count), 32'd1);
    end
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'h90 + i), 0);
    chk("wrap_full", 32'(full), 32'd1);
    repeat (4) cyc(0, 8'h00, 1);
    chk("wrap_empty", 32'(empty), 32'd1);
    chk("wrap_not_full", 32'(full), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      automatic int unsigned phase = (i / 150) % 3;
      automatic int unsigned wb = (phase == 0) ? 80 : (phase == 1) ? 20 : 50;
      automatic int unsigned rb = (phase == 0) ? 20 : (phase == 1) ? 80 : 50;
      wr = ($urandom_range(0, 99) < wb);
      rd = ($urandom_range(0, 99) < rb);
      wr_data = 8'($urandom);
      if (i == 1500) begin
        wr = 1;
        #3 rst_n = 1'b0;
        #1 chk_reset_vals();
        @(posedge clk); #1;
        rst_n = 1'b1;
        wr = 1; rd = 0; wr_data = 8'h5A;
        #1;
        chk("post_rst_waddr", 32'(ram_write_address), 32'd0);
        chk("post_rst_wen", 32'(ram_write_en), 32'd1);
      end
      @(posedge clk); #1;
    end
    wr = 0; rd = 0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and flag controller for the synchronous FIFO, sitting directly upstream of `sync_dual_port_ram`. It accepts push/pop requests from the user, drives the RAM's `write_en`, `write_address` and `read_address` ports, and returns the RAM's `read_data_out` as first-word-fall-through read data. It maintains full/empty/count status and sticky overflow/underflow errors.

## Interface
- `ADDRESS_WIDTH`, default 12: RAM address width; depth = 2**ADDRESS_WIDTH.
- `DATA_WIDTH`, default 8: word width, passed through between the user side and the RAM side.
- `AFULL_THRESH`, default 2**ADDRESS_WIDTH-1: almost_full level (only with `FIFO_CTRL_THRESH_EN`).
- `AEMPTY_THRESH`, default 1: almost_empty level (only with `FIFO_CTRL_THRESH_EN`).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr`  in  1  push request.
- `wr_data`  in  DATA_WIDTH  push data.
- `rd`  in  1  pop request.
- `rd_data`  out  DATA_WIDTH  head-of-FIFO word; valid when `empty`=0.
- `full`, `empty`  out  1  status flags.
- `count`  out  ADDRESS_WIDTH+1  occupancy, 0..2**ADDRESS_WIDTH.
- `overflow`, `underflow`  out  1  sticky errors; cleared only by reset.
- `almost_full`, `almost_empty`  out  1  threshold flags (only with `FIFO_CTRL_THRESH_EN`).
- `ram_write_en`  out  1  to RAM `write_en`.
- `ram_write_address`, `ram_read_address`  out  ADDRESS_WIDTH  to RAM.
- `ram_write_data`  out  DATA_WIDTH  to RAM `write_data_in`.
- `ram_read_data`  in  DATA_WIDTH  from RAM `read_data_out`.

## Operation
- Pointers `wptr` and `rptr` are ADDRESS_WIDTH+1 bits wide, with the MSB used as a wrap bit.
  - `empty` = (`wptr` == `rptr`).
  - `full` = LSBs equal and MSBs differ.
- A push is accepted iff `wr` && !`full`. A pop is accepted iff `rd` && !`empty`.
- `ram_write_en` = push_accepted && `rst_n`. `ram_write_address` = `wptr[ADDRESS_WIDTH-1:0]`. `ram_write_data` = `wr_data`.
- `ram_read_address` = next `rptr` LSBs, i.e. `rptr`+1 if a pop is accepted, else `rptr`. It is driven combinationally, so the RAM's registered read address always tracks the head.
- `rd_data` = `ram_read_data`, combinational pass-through.
- `count` = `wptr` − `rptr`, modulo 2**(ADDRESS_WIDTH+1).
- Push while full: no write and no pointer change; `overflow` is set. The same applies when `rd` is also asserted while full: the pop proceeds and the push is still dropped.
- Pop while empty: no pointer change; `underflow` is set. If `wr` is also asserted, the push proceeds.
- Push and pop accepted in the same cycle: both pointers advance and `count`, `full` and `empty` are unchanged.
- Pointers wrap naturally. The LSBs roll over from 2**ADDRESS_WIDTH−1 to 0 and the MSB toggles.

## Timing
- Reset values, applied asynchronously on `rst_n` low:
  - `wptr`=`rptr`=0, `count`=0.
  - `empty`=1, `full`=0.
  - `overflow`=`underflow`=0.
  - `almost_empty`=1, `almost_full`=0.
  - `ram_write_en`=0, `ram_read_address`=0.
- RAM contents are not cleared by reset.
- All flags and `count` are registered or derived from registered pointers. They update on the clock edge that accepts the operation.
- Push-to-visible latency:
  - The word pushed at edge N updates `empty` after edge N.
  - The same word appears on `rd_data` after edge N, because the RAM write and the read-address register land on the same edge and the RAM read is asynchronous.
- Pop latency: `rd_data` shows the next word after the popping edge.
- Reset asserted mid-operation drops all stored words immediately. The first push after reset release lands at address 0.

## Configuration
- `FIFO_CTRL_THRESH_EN` defined:
  - `almost_full` = (`count` >= `AFULL_THRESH`).
  - `almost_empty` = (`count` <= `AEMPTY_THRESH`).
  - Both are registered, updating on the same edge as `count`.
- `FIFO_CTRL_THRESH_EN` undefined: the `almost_full` and `almost_empty` ports and the `AFULL_THRESH`/`AEMPTY_THRESH` parameters are absent.

## Structure
- Shared package `fifo_pkg` holds:
  - pointer-width constant derivation (ADDRESS_WIDTH+1);
  - a status-flag bit-index enumeration (FULL, EMPTY, OVF, UDF).
- One sub-module, `fifo_ptr`: a wrap-bit pointer register with `inc` input, registered `ptr` output and combinational `ptr_next` output. It is instantiated twice, once for write and once for read.
- The RAM itself is instantiated by the FIFO top, not by `fifo_ctrl`.

## Test plan
All scenarios use ADDRESS_WIDTH=2 (depth 4).
- Reset, then idle: `empty`=1, `full`=0, `count`=0, `ram_write_en`=0, `ram_read_address`=0.
- Push 0xA1, 0xB2, 0xC3, 0xD4 → `full`=1, `count`=4. Then pop four times → `rd_data` sequence A1, B2, C3, D4, ending with `empty`=1.
- Push 0xEE while full → `overflow`=1 and `count` stays 4. Push and pop together while full → pop returns head, `count`=3, 0xEE is never read.
- Pop while empty → `underflow`=1. Push 0x55 and pop in the same cycle while empty → `count`=1 and `rd_data`=0x55 after the edge.
- Run 10 push/pop pairs to wrap the pointers twice → data order is preserved and `count` stays 1; a full→empty transition after the wrap flags correctly.
- With `FIFO_CTRL_THRESH_EN`, AFULL_THRESH=3 and AEMPTY_THRESH=1 → `almost_full` rises on the 3rd push; `almost_empty` falls on the 2nd push. Assert `rst_n` low mid-run → all outputs return to reset values immediately.
